dircc_mem_stream_reader: RTL and testbench

DIRCC_MEM_STREAM_READER -- requirements
Module: dircc_mem_stream_reader

---
 rtl/dircc_mem_reader_pkg.sv | 15 +
 rtl/dircc_sync_fifo.sv | 52 +++++
 rtl/dircc_mem_stream_reader.sv | 128 ++++++++++++
 tb/tb_dircc_mem_stream_reader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dircc_mem_reader_pkg.sv
// Shared defaults and FSM encoding for the halfword memory-to-stream reader.
package dircc_mem_reader_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_LEN_W  = 14;
    localparam int MEM_WORDS  = 15000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/dircc_sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop in the same cycle are legal even when full.
module dircc_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dircc_mem_stream_reader.sv
// Reads a run of halfwords from a fixed-latency memory port and streams them out with sop/eop framing.
module dircc_mem_stream_reader
    import dircc_mem_reader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [1:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_sop,
    output logic              src_eop,
    output logic [1:0]        fsm_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fsm_state_e        state;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_idx;
    logic [LEN_W-1:0]  last_idx;
    logic              rd_pend;
    logic              pend_sop;
    logic              pend_eop;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W+1:0] fifo_head;
    logic              issue;
    logic              last_issue;
    logic              pop;

    assign cmd_ready      = (state == ST_IDLE);
    assign busy           = (state == ST_READ) || (state == ST_DRAIN);
    assign fsm_state      = state;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 2'b11;
    assign mem_clken      = 1'b1;
    assign mem_address    = rd_addr;
    assign mem_chipselect = issue;

    // Reads in flight count against capacity so every returning word has a free slot.
    assign issue      = (state == ST_READ) && !fifo_full
                        && ((fifo_count + CW'(rd_pend)) < CW'(FIFO_DEPTH));
    assign last_issue = issue && (rd_idx == last_idx);

    assign src_valid = !fifo_empty;
    assign pop       = src_valid && src_ready;
    assign {src_sop, src_eop, src_data} = fifo_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rd_addr  <= '0;
            rd_idx   <= '0;
            last_idx <= '0;
            rd_pend  <= 1'b0;
            pend_sop <= 1'b0;
            pend_eop <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_pend  <= issue;
            pend_sop <= issue && (rd_idx == '0);
            pend_eop <= last_issue;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            rd_addr  <= cmd_addr;
                            rd_idx   <= '0;
                            last_idx <= cmd_len - LEN_W'(1);
                            state    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        rd_idx  <= rd_idx + LEN_W'(1);
                        if (last_issue) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && src_eop) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dircc_sync_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rd_pend),
        .wr_data ({pend_sop, pend_eop, mem_readdata}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_dircc_mem_stream_reader.sv
// Directed bench: driver pushes expected beats/addresses, a negedge monitor pops and compares.
module tb_dircc_mem_stream_reader;

    localparam int W = 18;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [13:0] cmd_addr;
    logic [13:0] cmd_len;
    logic        busy;
    logic        done;
    logic [13:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [1:0]  mem_byteenable;
    logic        mem_clken;
    logic [15:0] mem_readdata;
    logic        src_valid;
    logic        src_ready;
    logic [15:0] src_data;
    logic        src_sop;
    logic        src_eop;
    logic [1:0]  fsm_state;

    logic [15:0] mem [0:16383];
    logic [W-1:0]  exp_q[$];
    logic [13:0]   addr_q[$];

    int   vectors = 0;
    int   miscompares = 0;
    int   outstanding = 0;
    int   stall = 0;
    logic eop_seen = 1'b0;
    logic zero_acc = 1'b0;
    logic was_reset = 1'b0;
    logic hold_chk = 1'b0;
    logic [W-1:0] held = '0;
    logic end_check = 1'b0;
    logic end_done = 1'b0;

    // clock / reset
    always #5 clk = ~clk;

    dircc_mem_stream_reader dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_data       (src_data),
        .src_sop        (src_sop),
        .src_eop        (src_eop),
        .fsm_state      (fsm_state)
    );

    // memory slave: data one cycle after strobe, garbage otherwise
    always @(posedge clk) begin
        mem_readdata <= mem_chipselect ? mem[mem_address] : 16'hDEAD;
    end

    always @(posedge clk) begin
        zero_acc <= !reset && cmd_valid && cmd_ready && (cmd_len == 14'd0);
    end

    // driver tasks
    task automatic push_beat(input logic [13:0] a, input logic [15:0] d, input logic sop, input logic eop);
        exp_q.push_back({sop, eop, d});
        addr_q.push_back(a);
    endtask

    task automatic push_xfer(input logic [13:0] a, input int len);
        logic [13:0] ai;
        for (int i = 0; i < len; i++) begin
            ai = a + 14'(i);
            push_beat(ai, mem[ai], i == 0, i == len - 1);
        end
    endtask

    task automatic send_cmd(input logic [13:0] a, input logic [13:0] l);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (i > 2 && !busy && exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] exp_b;
        logic [13:0]  exp_a;
        if (reset) begin
            vectors++;
            if (busy || done || mem_chipselect || src_valid) begin
                miscompares++;
                $display("FAIL reset_outputs: busy=%0b done=%0b cs=%0b valid=%0b, expected all 0",
                         busy, done, mem_chipselect, src_valid);
            end
            exp_q.delete();
            addr_q.delete();
            outstanding = 0;
            eop_seen = 1'b0;
            stall = 0;
            hold_chk = 1'b0;
        end else begin
            if (was_reset) begin
                vectors++;
                if (cmd_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL cmd_ready_after_reset: got %b, expected 1", cmd_ready);
                end
            end
            if (eop_seen || zero_acc) begin
                vectors++;
                if (done !== 1'b1) begin
                    miscompares++;
                    $display("FAIL done_pulse: got %b, expected 1", done);
                end
            end else if (done !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL done_unexpected: got %b, expected 0", done);
            end
            eop_seen = 1'b0;
            if (hold_chk && src_valid) begin
                vectors++;
                if ({src_sop, src_eop, src_data} !== held) begin
                    miscompares++;
                    $display("FAIL hold_stable: got %h, expected %h", {src_sop, src_eop, src_data}, held);
                end
            end
            hold_chk = src_valid && !src_ready;
            held = {src_sop, src_eop, src_data};
            if (mem_chipselect) begin
                vectors++;
                if (outstanding >= 4) begin
                    miscompares++;
                    $display("FAIL read_window: got %0d outstanding at strobe, expected < 4", outstanding);
                end
                outstanding++;
                vectors++;
                if (addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL read_addr: got strobe at %h, expected no strobe", mem_address);
                end else begin
                    exp_a = addr_q.pop_front();
                    if (mem_address !== exp_a) begin
                        miscompares++;
                        $display("FAIL read_addr: got %h, expected %h", mem_address, exp_a);
                    end
                end
            end
            if (src_valid && src_ready) begin
                outstanding--;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat: got data=%h sop=%0b eop=%0b, expected no beat", src_data, src_sop, src_eop);
                end else begin
                    exp_b = exp_q.pop_front();
                    if ({src_sop, src_eop, src_data} !== exp_b) begin
                        miscompares++;
                        $display("FAIL beat: got sop=%0b eop=%0b data=%h, expected sop=%0b eop=%0b data=%h",
                                 src_sop, src_eop, src_data, exp_b[17], exp_b[16], exp_b[15:0]);
                    end
                end
                if (src_eop) eop_seen = 1'b1;
            end
            if ((exp_q.size() != 0) && src_ready && !src_valid && !mem_chipselect) stall++;
            else stall = 0;
            if (stall > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL stall: got no progress for %0d cycles, expected %0d more beats", stall, exp_q.size());
                exp_q.delete();
                addr_q.delete();
                stall = 0;
            end
            if (end_check && !end_done) begin
                vectors++;
                if (exp_q.size() != 0 || addr_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL leftover: got %0d beats and %0d reads pending, expected 0 and 0",
                             exp_q.size(), addr_q.size());
                end
                end_done = 1'b1;
            end
        end
        was_reset = reset;
    end

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'(i) ^ 16'hC35A;
        mem[14'h0010] = 16'h00A1;
        mem[14'h0011] = 16'h00A2;
        mem[14'h0012] = 16'h00A3;
        mem[14'h0013] = 16'h00A4;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        src_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // basic 4-beat transfer with hand-computed data
        push_beat(14'h0010, 16'h00A1, 1'b1, 1'b0);
        push_beat(14'h0011, 16'h00A2, 1'b0, 1'b0);
        push_beat(14'h0012, 16'h00A3, 1'b0, 1'b0);
        push_beat(14'h0013, 16'h00A4, 1'b0, 1'b1);
        send_cmd(14'h0010, 14'd4);
        wait_idle();

        // zero length: done only
        send_cmd(14'h0020, 14'd0);
        wait_idle();

        // back-pressure during a 10-beat transfer
        push_xfer(14'h0040, 10);
        send_cmd(14'h0040, 14'd10);
        repeat (2) begin
            @(posedge clk); #1;
        end
        src_ready = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        src_ready = 1'b1;
        wait_idle();

        // address wrap: 3FFE, 3FFF, 0000
        push_beat(14'h3FFE, mem[14'h3FFE], 1'b1, 1'b0);
        push_beat(14'h3FFF, mem[14'h3FFF], 1'b0, 1'b0);
        push_beat(14'h0000, mem[14'h0000], 1'b0, 1'b1);
        send_cmd(14'h3FFE, 14'd3);
        wait_idle();

        // reset during beat 2 of an 8-beat transfer, then a single beat
        push_xfer(14'h0100, 8);
        send_cmd(14'h0100, 14'd8);
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        push_beat(14'h0200, mem[14'h0200], 1'b1, 1'b1);
        send_cmd(14'h0200, 14'd1);
        wait_idle();

        // command pulsed while busy must be ignored
        push_xfer(14'h0080, 6);
        send_cmd(14'h0080, 14'd6);
        repeat (2) begin
            @(posedge clk); #1;
        end
        cmd_addr  = 14'h0300;
        cmd_len   = 14'd2;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle();

        end_check = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
